// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with a 4-entry TX FIFO,
// a programmable bit divisor and a drain interrupt.
module uart_tx_mmio #(
   parameter logic [15:0] DEFAULT_DIV = 16'd16,
   parameter int          FIFO_DEPTH  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   input  logic [3:0]  sel,
   output logic [31:0] data_o,
   output logic        tx_o,
   output logic        int_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_e;

   localparam logic [2:0] DEPTH = 3'(FIFO_DEPTH);

   state_e      state_q, state_d;
   logic [7:0]  fifo_q [4];
   logic [1:0]  rptr_q, wptr_q;
   logic [2:0]  cnt_q, cnt_d;
   logic        ovf_q, ovf_d;
   logic [15:0] div_q, div_d;
   logic        irq_en_q, irq_en_d;
   logic [7:0]  shreg_q;
   logic [2:0]  bidx_q;
   logic [15:0] timer_q;
   logic [15:0] deff_q;
   logic        int_q;

   logic        wr, rd;
   logic        push, push_ok, pop;
   logic        empty, full, busy;
   logic        bit_end;
   logic [15:0] deff_new;
   logic        unused_bits;

   assign unused_bits = ^{addr[31:4], addr[1:0], data[31:17]};

   assign wr       = ce & we;
   assign rd       = ce & ~we;
   assign empty    = (cnt_q == 3'd0);
   assign full     = (cnt_q == DEPTH);
   assign push     = wr & (addr[3:2] == 2'b00) & sel[0];
   assign push_ok  = push & ~full;
   assign bit_end  = (timer_q == 16'd0);
   assign deff_new = (div_q == 16'd0) ? 16'd1 : div_q;

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (!empty) state_d = S_START;
         S_START: if (bit_end) state_d = S_DATA;
         S_DATA:  if (bit_end && bidx_q == 3'd7) state_d = S_STOP;
         S_STOP:  if (bit_end) state_d = empty ? S_IDLE : S_START;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      tx_o = 1'b1;
      busy = 1'b1;
      pop  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            pop  = ~empty;
         end
         S_START: tx_o = 1'b0;
         S_DATA:  tx_o = shreg_q[0];
         S_STOP:  pop  = bit_end & ~empty;
         default: busy = 1'b0;
      endcase
   end

   // Register-file next state
   always_comb begin
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      div_d    = div_q;
      irq_en_d = irq_en_q;
      case ({push_ok, pop})
         2'b10:   cnt_d = cnt_q + 3'd1;
         2'b01:   cnt_d = cnt_q - 3'd1;
         default: cnt_d = cnt_q;
      endcase
      if (push && full) ovf_d = 1'b1;
      if (wr && addr[3:2] == 2'b01 && sel[0] && data[3])
         ovf_d = 1'b0;
      if (wr && addr[3:2] == 2'b10) begin
         if (sel[0]) div_d[7:0]  = data[7:0];
         if (sel[1]) div_d[15:8] = data[15:8];
         if (sel[2]) irq_en_d    = data[16];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rptr_q   <= 2'd0;
         wptr_q   <= 2'd0;
         cnt_q    <= 3'd0;
         ovf_q    <= 1'b0;
         div_q    <= DEFAULT_DIV;
         irq_en_q <= 1'b0;
         int_q    <= 1'b0;
      end else begin
         if (push_ok) wptr_q <= wptr_q + 2'd1;
         if (pop)     rptr_q <= rptr_q + 2'd1;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         div_q    <= div_d;
         irq_en_q <= irq_en_d;
         int_q    <= irq_en_q & empty & ~busy;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_q[wptr_q] <= data[7:0];
   end

   // Divisor is latched per frame so CTRL writes never disturb a frame
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg_q <= 8'd0;
         bidx_q  <= 3'd0;
         timer_q <= 16'd0;
         deff_q  <= 16'd1;
      end else if (pop) begin
         shreg_q <= fifo_q[rptr_q];
         bidx_q  <= 3'd0;
         timer_q <= deff_new - 16'd1;
         deff_q  <= deff_new;
      end else if (busy) begin
         if (bit_end) begin
            timer_q <= deff_q - 16'd1;
            if (state_q == S_DATA) begin
               shreg_q <= {1'b0, shreg_q[7:1]};
               bidx_q  <= bidx_q + 3'd1;
            end
         end else begin
            timer_q <= timer_q - 16'd1;
         end
      end
   end

   always_comb begin
      data_o = 32'd0;
      if (rd) begin
         case (addr[3:2])
            2'b01: data_o = {25'd0, cnt_q, ovf_q, full, empty, busy};
            2'b10: data_o = {15'd0, irq_en_q, div_q};
            default: data_o = 32'd0;
         endcase
      end
   end

   assign int_o = int_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio: register map, framing,
// FIFO overflow, interrupt timing, divisor 0 and mid-frame reset.
module tb_uart_tx_mmio;

   localparam logic [31:0] A_TX   = 32'h0;
   localparam logic [31:0] A_STAT = 32'h4;
   localparam logic [31:0] A_CTRL = 32'h8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce = 1'b0;
   logic        we = 1'b0;
   logic [31:0] addr = '0;
   logic [31:0] data = '0;
   logic [3:0]  sel = '0;
   logic [31:0] data_o;
   logic        tx_o;
   logic        int_o;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic txlog  [0:1023];
   logic intlog [0:1023];

   uart_tx_mmio dut (
      .clk(clk), .rst(rst), .ce(ce), .we(we),
      .addr(addr), .data(data), .sel(sel),
      .data_o(data_o), .tx_o(tx_o), .int_o(int_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Index = number of rising edges seen so far
   always @(negedge clk) begin
      if (cyc < 1024) begin
         txlog[cyc]  = tx_o;
         intlog[cyc] = int_o;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int e);
      ce = 1'b1; we = 1'b1; addr = a; data = d; sel = s;
      @(posedge clk);
      #1;
      e = cyc;
      ce = 1'b0; we = 1'b0; sel = '0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      ce = 1'b1; we = 1'b0; addr = a;
      #1;
      d = data_o;
      ce = 1'b0;
   endtask

   task automatic wait_edge(input int e);
      while (cyc < e) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [63:0] exp_frame(input logic [7:0] b,
                                             input int d);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < 10 * d; k++) begin
         if (k < d)          v[k] = 1'b0;
         else if (k < 9 * d) v[k] = b[(k - d) / d];
         else                v[k] = 1'b1;
      end
      return v;
   endfunction

   function automatic logic [63:0] obs_frame(input int base,
                                             input int len);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < len; k++) v[k] = txlog[base + k];
      return v;
   endfunction

   initial begin
      int n, e, f, busy_n, ones, zeros;
      logic [31:0] r;

      // Reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_tx", 64'(tx_o), 64'd1);
      chk("rst_int", 64'(int_o), 64'd0);
      rd(A_STAT, r); chk("rst_status", 64'(r), 64'h2);
      rd(A_CTRL, r); chk("rst_ctrl", 64'(r), 64'h10);

      // Single byte, div 4
      wr(A_CTRL, 32'h4, 4'b0011, e);
      wr(A_TX, 32'h55, 4'b0001, n);
      rd(A_STAT, r); chk("one_status_n", 64'(r), 64'h10);
      busy_n = 0;
      for (int i = 1; i <= 41; i++) begin
         wait_edge(n + i);
         rd(A_STAT, r);
         busy_n += int'(r[0]);
      end
      wait_edge(n + 42);
      chk("one_busy_cycles", 64'(busy_n), 64'd40);
      chk("one_frame", obs_frame(n + 1, 40), exp_frame(8'h55, 4));
      chk("one_idle_after", 64'({txlog[n], txlog[n + 41]}), 64'b11);

      // Back-to-back and overflow, div 2
      wr(A_CTRL, 32'h2, 4'b0011, e);
      wr(A_TX, 32'hA1, 4'b0001, n);
      for (int i = 0; i < 5; i++) wr(A_TX, 32'hA2 + i, 4'b0001, e);
      rd(A_STAT, r); chk("b2b_status_full", 64'(r), 64'h4D);
      wait_edge(n + 103);
      for (int k = 0; k < 5; k++)
         chk($sformatf("b2b_frame%0d", k),
             obs_frame(n + 1 + 20 * k, 20),
             exp_frame(8'hA1 + 8'(k), 2));
      chk("b2b_idle_after", 64'(txlog[n + 101]), 64'd1);
      rd(A_STAT, r); chk("b2b_status_ovf", 64'(r), 64'hA);
      wr(A_STAT, 32'h8, 4'b0001, e);
      rd(A_STAT, r); chk("b2b_ovf_clear", 64'(r), 64'h2);

      // Interrupt, div 3
      wr(A_CTRL, 32'h0001_0003, 4'b0111, e);
      wr(A_TX, 32'h5A, 4'b0001, n);
      wait_edge(n + 34);
      chk("irq_before_push", 64'(intlog[n]), 64'd1);
      ones = 0;
      for (int k = n + 1; k <= n + 31; k++) ones += int'(intlog[k]);
      chk("irq_low_busy", 64'(ones), 64'd0);
      chk("irq_rise", 64'(intlog[n + 32]), 64'd1);
      chk("irq_frame", obs_frame(n + 1, 30), exp_frame(8'h5A, 3));
      wr(A_CTRL, 32'h0, 4'b0100, f);
      wait_edge(f + 2);
      chk("irq_clear", 64'({intlog[f], intlog[f + 1]}), 64'b10);

      // Divisor 0
      wr(A_CTRL, 32'h0, 4'b0011, e);
      wr(A_TX, 32'h3C, 4'b0001, n);
      wait_edge(n + 13);
      chk("div0_frame", obs_frame(n + 1, 10), exp_frame(8'h3C, 1));
      chk("div0_idle", 64'(txlog[n + 11]), 64'd1);

      // Bus isolation
      ce = 1'b0; we = 1'b1; addr = A_TX; data = 32'h77; sel = 4'hF;
      repeat (3) @(posedge clk);
      #1;
      chk("iso_dout_ce0", 64'(data_o), 64'd0);
      we = 1'b0; addr = A_STAT; sel = '0;
      #1;
      chk("iso_dout_rd_ce0", 64'(data_o), 64'd0);
      rd(A_STAT, r); chk("iso_no_push", 64'(r), 64'h2);
      ce = 1'b1; we = 1'b1; addr = A_STAT; data = '0; sel = '0;
      #1;
      chk("iso_dout_we1", 64'(data_o), 64'd0);
      @(posedge clk);
      #1 ce = 1'b0; we = 1'b0;

      // Reset mid-frame, div 4, two bytes queued
      wr(A_CTRL, 32'h4, 4'b0011, e);
      wr(A_TX, 32'h11, 4'b0001, n);
      wr(A_TX, 32'h22, 4'b0001, e);
      wr(A_TX, 32'h33, 4'b0001, e);
      wait_edge(n + 10);
      rd(A_STAT, r); chk("mid_status_pre", 64'(r), 64'h21);
      wait_edge(n + 17);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("mid_tx_after_rst", 64'(tx_o), 64'd1);
      rd(A_STAT, r); chk("mid_status_post", 64'(r), 64'h2);
      rd(A_CTRL, r); chk("mid_ctrl_post", 64'(r), 64'h10);
      e = cyc;
      wait_edge(e + 61);
      chk("mid_bit3_low", 64'(txlog[n + 17]), 64'd0);
      zeros = 0;
      for (int k = e; k < e + 60; k++) zeros += int'(!txlog[k]);
      chk("mid_no_frames", 64'(zeros), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
